// File: rtl/risc_v_32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_32_pkg
// Description : Shared types for the dual-issue RV32I data-memory arbiter:
//               arbiter state encoding and load/store size codes.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_v_32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage
`default_nettype wire

// File: rtl/risc_v_32_lsu_fmt.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_32_lsu_fmt
// Description : Per-lane access formatter. Derives byte enables, lane-
//               replicated store data and the misalignment flag from the
//               low address bits and the access size.
// Ports       : i_addr_lo  - byte offset within the word (addr[1:0])
//               i_size     - 0 byte, 1 half, 2/3 word
//               i_wdata    - store data, right-justified
//               o_be       - byte enables
//               o_wdata    - store data replicated across byte lanes
//               o_misalign - half on odd address or word not on a word boundary
// Revision    : 1.0 - initial release
// ============================================================================
module risc_v_32_lsu_fmt
  import risc_v_32_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    i_addr_lo,
  input  logic [1:0]    i_size,
  input  logic [DW-1:0] i_wdata,
  output logic [3:0]    o_be,
  output logic [DW-1:0] o_wdata,
  output logic          o_misalign
);

  always_comb begin
    o_be       = 4'hF;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    case (i_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_addr_lo[0];
      end
      // Size code 3 is not a legal RV32I width; it is handled as a word.
      default: begin
        o_be       = 4'hF;
        o_wdata    = i_wdata;
        o_misalign = (i_addr_lo != 2'b00);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/risc_v_32_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_32_mem_arb
// Description : Data-memory port arbiter for the dual-issue RV32I core.
//               Serialises the loads/stores of one issue bundle onto the
//               single memory port, lane 0 before lane 1, and stalls the
//               pipeline until every access of the bundle has completed.
// Ports       : clk, rst                 - clock, sync active-high reset
//               exN_rmem/wmem/addr/wdata/size - lane N request from EX
//               exN_done/misalign/rdata  - lane N completion and load word
//               mem_req/we/addr/wdata/be - registered memory request
//               mem_ack, mem_rdata       - memory handshake and read data
//               stall                    - holds the bundle in EX
// Revision    : 1.0 - initial release
// ============================================================================
module risc_v_32_mem_arb
  import risc_v_32_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex0_rmem,
  input  logic          ex0_wmem,
  input  logic [AW-1:0] ex0_addr,
  input  logic [DW-1:0] ex0_wdata,
  input  logic [1:0]    ex0_size,
  input  logic          ex1_rmem,
  input  logic          ex1_wmem,
  input  logic [AW-1:0] ex1_addr,
  input  logic [DW-1:0] ex1_wdata,
  input  logic [1:0]    ex1_size,
  output logic          ex0_done,
  output logic          ex1_done,
  output logic          ex0_misalign,
  output logic          ex1_misalign,
  output logic [DW-1:0] ex0_rdata,
  output logic [DW-1:0] ex1_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  // Lane formatting
  logic [3:0]    w_fmt0_be,  w_fmt1_be;
  logic [DW-1:0] w_fmt0_wd,  w_fmt1_wd;
  logic          w_fmt0_mis, w_fmt1_mis;

  risc_v_32_lsu_fmt #(.DW(DW)) u_fmt0 (
    .i_addr_lo  (ex0_addr[1:0]),
    .i_size     (ex0_size),
    .i_wdata    (ex0_wdata),
    .o_be       (w_fmt0_be),
    .o_wdata    (w_fmt0_wd),
    .o_misalign (w_fmt0_mis)
  );

  risc_v_32_lsu_fmt #(.DW(DW)) u_fmt1 (
    .i_addr_lo  (ex1_addr[1:0]),
    .i_size     (ex1_size),
    .i_wdata    (ex1_wdata),
    .o_be       (w_fmt1_be),
    .o_wdata    (w_fmt1_wd),
    .o_misalign (w_fmt1_mis)
  );

  // Registers
  state_t        r_state;
  logic          r_done_f0, r_done_f1;
  logic          r_ex0_done, r_ex1_done;
  logic          r_ex0_mis, r_ex1_mis;
  logic [DW-1:0] r_ex0_rdata, r_ex1_rdata;
  logic          r_mem_req, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [3:0]    r_mem_be;

  // Request / stall decode
  logic w_pend0, w_pend1, w_stall, w_ack;

  assign w_pend0 = (ex0_rmem | ex0_wmem) & ~r_done_f0;
  assign w_pend1 = (ex1_rmem | ex1_wmem) & ~r_done_f1;
  assign w_stall = w_pend0 | w_pend1;
  // Only an acknowledge against an outstanding request counts.
  assign w_ack   = mem_ack & r_mem_req;

  // Next state and per-cycle events
  state_t w_state_nxt;
  logic   w_issue0, w_issue1;
  logic   w_ack0, w_ack1;
  logic   w_mis0, w_mis1;

  always_comb begin
    w_state_nxt = r_state;
    w_issue0    = 1'b0;
    w_issue1    = 1'b0;
    w_ack0      = 1'b0;
    w_ack1      = 1'b0;
    w_mis0      = 1'b0;
    w_mis1      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A misaligned lane completes here without touching memory; the
        // other lane is looked at on the following cycle.
        if (w_pend0) begin
          if (w_fmt0_mis) begin
            w_mis0 = 1'b1;
          end else begin
            w_issue0    = 1'b1;
            w_state_nxt = ST_BUSY0;
          end
        end else if (w_pend1) begin
          if (w_fmt1_mis) begin
            w_mis1 = 1'b1;
          end else begin
            w_issue1    = 1'b1;
            w_state_nxt = ST_BUSY1;
          end
        end
      end
      ST_BUSY0: begin
        if (w_ack) begin
          w_ack0 = 1'b1;
          // Chain straight into lane 1 unless it must be resolved as a
          // misaligned access from IDLE.
          if (w_pend1 && !w_fmt1_mis) begin
            w_issue1    = 1'b1;
            w_state_nxt = ST_BUSY1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_BUSY1: begin
        if (w_ack) begin
          w_ack1      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_done_f0   <= 1'b0;
      r_done_f1   <= 1'b0;
      r_ex0_done  <= 1'b0;
      r_ex1_done  <= 1'b0;
      r_ex0_mis   <= 1'b0;
      r_ex1_mis   <= 1'b0;
      r_ex0_rdata <= '0;
      r_ex1_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ex0_done <= w_ack0 | w_mis0;
      r_ex1_done <= w_ack1 | w_mis1;
      r_ex0_mis  <= w_mis0;
      r_ex1_mis  <= w_mis1;

      if (w_ack0) r_ex0_rdata <= mem_rdata;
      if (w_ack1) r_ex1_rdata <= mem_rdata;

      // Flags live for exactly one bundle: cleared when the bundle advances.
      if (!w_stall) begin
        r_done_f0 <= 1'b0;
        r_done_f1 <= 1'b0;
      end else begin
        if (w_ack0 | w_mis0) r_done_f0 <= 1'b1;
        if (w_ack1 | w_mis1) r_done_f1 <= 1'b1;
      end

      // Request fields load on state entry and hold through the ack cycle.
      if (w_issue0) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= ex0_wmem;
        r_mem_addr  <= {ex0_addr[AW-1:2], 2'b00};
        r_mem_wdata <= w_fmt0_wd;
        r_mem_be    <= w_fmt0_be;
      end else if (w_issue1) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= ex1_wmem;
        r_mem_addr  <= {ex1_addr[AW-1:2], 2'b00};
        r_mem_wdata <= w_fmt1_wd;
        r_mem_be    <= w_fmt1_be;
      end else if (w_ack0 | w_ack1) begin
        r_mem_req <= 1'b0;
      end
    end
  end

  assign ex0_done     = r_ex0_done;
  assign ex1_done     = r_ex1_done;
  assign ex0_misalign = r_ex0_mis;
  assign ex1_misalign = r_ex1_mis;
  assign ex0_rdata    = r_ex0_rdata;
  assign ex1_rdata    = r_ex1_rdata;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_be       = r_mem_be;
  assign stall        = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_risc_v_32_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_v_32_mem_arb
// Description : Self-checking bench for risc_v_32_mem_arb. A table of single
//               lane bundles against zero-wait memory, followed by directed
//               sequences for ordering, wait states, misalignment, reset
//               mid-access and back-to-back bundles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_v_32_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex0_rmem, ex0_wmem, ex1_rmem, ex1_wmem;
  logic [31:0] ex0_addr, ex0_wdata, ex1_addr, ex1_wdata;
  logic [1:0]  ex0_size, ex1_size;
  logic        ex0_done, ex1_done, ex0_misalign, ex1_misalign;
  logic [31:0] ex0_rdata, ex1_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall;

  always #5 clk = ~clk;

  risc_v_32_mem_arb #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .ex0_rmem(ex0_rmem), .ex0_wmem(ex0_wmem), .ex0_addr(ex0_addr),
    .ex0_wdata(ex0_wdata), .ex0_size(ex0_size),
    .ex1_rmem(ex1_rmem), .ex1_wmem(ex1_wmem), .ex1_addr(ex1_addr),
    .ex1_wdata(ex1_wdata), .ex1_size(ex1_size),
    .ex0_done(ex0_done), .ex1_done(ex1_done),
    .ex0_misalign(ex0_misalign), .ex1_misalign(ex1_misalign),
    .ex0_rdata(ex0_rdata), .ex1_rdata(ex1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  // Memory responder: acks after wait_cfg wait cycles, logs every access.
  int          wait_cfg;
  logic        force_ack;
  logic        mem_clear;
  logic [31:0] mem [0:255];
  int          acc_tot;
  int          rcnt;
  logic        log_we   [0:31];
  logic [31:0] log_addr [0:31];
  logic [31:0] log_wd   [0:31];
  logic [3:0]  log_be   [0:31];

  always @(negedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
      acc_tot = 0;
      rcnt    = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
    end else if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
    end else if (mem_req) begin
      if (rcnt == wait_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we)
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        log_we[acc_tot % 32]   = mem_we;
        log_addr[acc_tot % 32] = mem_addr;
        log_wd[acc_tot % 32]   = mem_wdata;
        log_be[acc_tot % 32]   = mem_be;
        acc_tot = acc_tot + 1;
        rcnt    = 0;
      end else begin
        mem_ack = 1'b0;
        rcnt    = rcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      rcnt    = 0;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Per-bundle observations
  int st_cyc, dn0, dn1, ms0, ms1, first_req, acc_base;

  // Called at posedge+1; returns at posedge+1 after the cycle where stall=0.
  task automatic run_bundle(
    input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0, input logic [1:0] s0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1, input logic [1:0] s1);
    logic fin;
    ex0_rmem = r0; ex0_wmem = w0; ex0_addr = a0; ex0_wdata = d0; ex0_size = s0;
    ex1_rmem = r1; ex1_wmem = w1; ex1_addr = a1; ex1_wdata = d1; ex1_size = s1;
    acc_base = acc_tot;
    st_cyc = 0; dn0 = 0; dn1 = 0; ms0 = 0; ms1 = 0; first_req = 0;
    fin = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ex0_done) dn0++;
      if (ex1_done) dn1++;
      if (ex0_misalign) ms0++;
      if (ex1_misalign) ms1++;
      if (mem_req && first_req == 0) first_req = c;
      if (!stall) begin
        fin = 1'b1;
        break;
      end
      st_cyc++;
      @(posedge clk); #1;
    end
    if (!fin) chk("bundle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        lane;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rdata;
    logic        e_mis;
    int          e_stall;
    int          e_acc;
  } vec_t;

  vec_t vecs [0:10];

  initial begin
    // lane rd wr addr wdata size | e_addr e_be e_wd e_rdata e_mis e_stall e_acc
    vecs[0]  = '{1'b0,1'b0,1'b1,32'h104,32'hDEADBEEF,2'd2, 32'h104,4'hF,32'hDEADBEEF,32'h0,       1'b0,2,1};
    vecs[1]  = '{1'b0,1'b0,1'b1,32'h201,32'h12345678,2'd0, 32'h200,4'h2,32'h78787878,32'h0,       1'b0,2,1};
    vecs[2]  = '{1'b0,1'b0,1'b1,32'h206,32'hCAFE1234,2'd1, 32'h204,4'hC,32'h12341234,32'h0,       1'b0,2,1};
    vecs[3]  = '{1'b1,1'b1,1'b0,32'h010,32'h00000000,2'd1, 32'h010,4'h3,32'h00000000,32'hA5000004,1'b0,2,1};
    vecs[4]  = '{1'b0,1'b0,1'b1,32'h108,32'h11223344,2'd3, 32'h108,4'hF,32'h11223344,32'h0,       1'b0,2,1};
    vecs[5]  = '{1'b1,1'b1,1'b0,32'h303,32'h00000055,2'd0, 32'h300,4'h8,32'h55555555,32'hA50000C0,1'b0,2,1};
    vecs[6]  = '{1'b0,1'b1,1'b0,32'h102,32'h00000000,2'd2, 32'h0,  4'h0,32'h0,       32'h0,       1'b1,1,0};
    vecs[7]  = '{1'b1,1'b0,1'b1,32'h105,32'h0000BEEF,2'd1, 32'h0,  4'h0,32'h0,       32'h0,       1'b1,1,0};
    vecs[8]  = '{1'b0,1'b1,1'b0,32'h103,32'h00000000,2'd0, 32'h100,4'h8,32'h00000000,32'hA5000040,1'b0,2,1};
    vecs[9]  = '{1'b0,1'b0,1'b0,32'h000,32'h00000000,2'd0, 32'h0,  4'h0,32'h0,       32'h0,       1'b0,0,0};
    vecs[10] = '{1'b1,1'b1,1'b0,32'h104,32'h00000000,2'd2, 32'h104,4'hF,32'h00000000,32'hDEADBEEF,1'b0,2,1};

    rst = 1'b1; mem_clear = 1'b1; force_ack = 1'b0; wait_cfg = 0;
    ex0_rmem = 0; ex0_wmem = 0; ex0_addr = 0; ex0_wdata = 0; ex0_size = 0;
    ex1_rmem = 0; ex1_wmem = 0; ex1_addr = 0; ex1_wdata = 0; ex1_size = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_clear = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd",   mem_wdata, 32'd0);
    chk("rst_mem_be",   {28'd0, mem_be}, 32'd0);
    chk("rst_rdata",    ex0_rdata | ex1_rdata, 32'd0);
    chk("rst_done",     {28'd0, ex0_done, ex1_done, ex0_misalign, ex1_misalign}, 32'd0);
    chk("rst_stall",    {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    // Table of single-lane bundles, zero-wait memory
    for (int v = 0; v < 11; v++) begin
      vec_t t;
      int   dn_l, dn_o, ms_l;
      t = vecs[v];
      if (t.lane == 1'b0)
        run_bundle(t.rd, t.wr, t.addr, t.wdata, t.size, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      else
        run_bundle(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, t.rd, t.wr, t.addr, t.wdata, t.size);
      dn_l = t.lane ? dn1 : dn0;
      dn_o = t.lane ? dn0 : dn1;
      ms_l = t.lane ? ms1 : ms0;
      chk($sformatf("v%0d_stall", v), st_cyc, t.e_stall);
      chk($sformatf("v%0d_acc", v), acc_tot - acc_base, t.e_acc);
      chk($sformatf("v%0d_done", v), dn_l, (t.rd | t.wr) ? 1 : 0);
      chk($sformatf("v%0d_other_done", v), dn_o, 0);
      chk($sformatf("v%0d_misalign", v), ms_l, t.e_mis ? 1 : 0);
      if (t.e_acc == 1) begin
        chk($sformatf("v%0d_first_req", v), first_req, 2);
        chk($sformatf("v%0d_addr", v), log_addr[acc_base % 32], t.e_addr);
        chk($sformatf("v%0d_we", v), {31'd0, log_we[acc_base % 32]}, {31'd0, t.wr});
        chk($sformatf("v%0d_be", v), {28'd0, log_be[acc_base % 32]}, {28'd0, t.e_be});
        chk($sformatf("v%0d_wdata", v), log_wd[acc_base % 32], t.e_wd);
        if (t.rd)
          chk($sformatf("v%0d_rdata", v), t.lane ? ex1_rdata : ex0_rdata, t.e_rdata);
      end else begin
        chk($sformatf("v%0d_no_req", v), first_req, 0);
      end
    end

    // Bundle sb 0x203 then lbu 0x203, two wait cycles per access
    wait_cfg = 2;
    run_bundle(1'b0, 1'b1, 32'h203, 32'h000000AB, 2'd0, 1'b1, 1'b0, 32'h203, 32'h0, 2'd0);
    chk("b2_stall", st_cyc, 7);
    chk("b2_acc", acc_tot - acc_base, 2);
    chk("b2_first_we", {31'd0, log_we[acc_base % 32]}, 32'd1);
    chk("b2_first_be", {28'd0, log_be[acc_base % 32]}, 32'h8);
    chk("b2_first_wd", log_wd[acc_base % 32], 32'hABABABAB);
    chk("b2_second_we", {31'd0, log_we[(acc_base + 1) % 32]}, 32'd0);
    chk("b2_second_addr", log_addr[(acc_base + 1) % 32], 32'h200);
    chk("b2_rdata1", ex1_rdata, 32'hAB007880);
    chk("b2_dones", {dn0[15:0], dn1[15:0]}, {16'd1, 16'd1});

    // Misaligned lw on lane 0, valid lw on lane 1
    wait_cfg = 0;
    run_bundle(1'b1, 1'b0, 32'h102, 32'h0, 2'd2, 1'b1, 1'b0, 32'h108, 32'h0, 2'd2);
    chk("mis_stall", st_cyc, 3);
    chk("mis_acc", acc_tot - acc_base, 1);
    chk("mis_acc_addr", log_addr[acc_base % 32], 32'h108);
    chk("mis_first_req", first_req, 3);
    chk("mis_flags", {ms0[7:0], ms1[7:0], dn0[7:0], dn1[7:0]}, 32'h01000101);
    chk("mis_rdata1", ex1_rdata, 32'h11223344);

    // Reset while lane 0 waits in BUSY0; then a stray late ack
    wait_cfg = 10;
    ex0_rmem = 1'b1; ex0_wmem = 1'b0; ex0_addr = 32'h10; ex0_size = 2'd2;
    ex1_rmem = 1'b0; ex1_wmem = 1'b0;
    begin
      logic seen;
      int   bad_req, bad_done;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (mem_req) begin
          seen = 1'b1;
          break;
        end
      end
      chk("rst_mid_req_seen", {31'd0, seen}, 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mid_stall", {31'd0, stall}, 32'd1);
      ex0_rmem = 1'b0;
      @(posedge clk); #1 force_ack = 1'b1;
      bad_req = 0; bad_done = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (mem_req) bad_req++;
        if (ex0_done || ex1_done) bad_done++;
      end
      force_ack = 1'b0;
      @(negedge clk);
      if (ex0_done || ex1_done) bad_done++;
      chk("late_ack_req", bad_req, 0);
      chk("late_ack_done", bad_done, 0);
      chk("late_ack_rdata", ex0_rdata, 32'h0);
      chk("late_ack_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
    end

    // Back-to-back bundles, one lw each, zero-wait
    wait_cfg = 0;
    run_bundle(1'b1, 1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    chk("bb1_stall", st_cyc, 2);
    chk("bb1_done", dn0, 1);
    chk("bb1_rdata", ex0_rdata, 32'hDEADBEEF);
    run_bundle(1'b1, 1'b0, 32'h010, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    chk("bb2_stall", st_cyc, 2);
    chk("bb2_first_req", first_req, 2);
    chk("bb2_done", dn0, 1);
    chk("bb2_acc", acc_tot - acc_base, 1);
    chk("bb2_rdata", ex0_rdata, 32'hA5000004);

    ex0_rmem = 1'b0;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc_v_32_mem_arb.md
# risc_v_32_mem_arb

Data-memory port arbiter for the dual-issue RV32I core. Sits between the two EX lanes and the single data-memory port. Serializes the loads and stores of one issue bundle in program order, with lane 0 older than lane 1. Stalls the pipeline until every memory access in the bundle has completed.

## Interface
- `AW`, 32: address width
- `DW`, 32: data width; fixed at 32 (the byte-enable logic depends on it)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `ex0_rmem`, `ex1_rmem` in 1: lane requests a load
- `ex0_wmem`, `ex1_wmem` in 1: lane requests a store
- `ex0_addr`, `ex1_addr` in AW: byte address from EX
- `ex0_wdata`, `ex1_wdata` in DW: store data, unaligned, in low bits
- `ex0_size`, `ex1_size` in 2: access size; 0 = byte, 1 = half, 2 = word
- `ex0_done`, `ex1_done` out 1: one-cycle pulse when the lane's access completes
- `ex0_misalign`, `ex1_misalign` out 1: pulses with done when the access was suppressed as misaligned
- `ex0_rdata`, `ex1_rdata` out DW: raw memory word, registered on ack and held until next ack
- `mem_req` out 1: memory request valid
- `mem_we` out 1: write
- `mem_addr` out AW: word-aligned address `{addr[31:2],2'b00}`
- `mem_wdata` out DW: lane-replicated store data
- `mem_be` out 4: byte enables
- `mem_ack` in 1: memory accepted (write) or returned data (read)
- `mem_rdata` in DW: read data, valid with `mem_ack`
- `stall` out 1: holds the issue bundle in EX

## Operation
- A lane requests when `rmem|wmem` is high.
- EX holds all lane inputs stable while `stall`=1.
- Per-lane completion flags `done_f0` and `done_f1`.
- `stall = (req0 & ~done_f0) | (req1 & ~done_f1)`, combinational.
- Both flags clear on any edge where `stall`=0, i.e. when the bundle advances.

FSM states: IDLE, BUSY0, BUSY1.
- IDLE:
  - if `req0 & ~done_f0`, go to BUSY0;
  - else if `req1 & ~done_f1`, go to BUSY1.
- BUSY0 / BUSY1:
  - `mem_req` = 1, with fields from that lane.
  - On `mem_ack`: latch `exN_rdata`, pulse `exN_done`, set `done_fN`.
  - From BUSY0 go to BUSY1 if `req1`; otherwise go to IDLE. From BUSY1 go to IDLE.
- Lane 0 is always served before lane 1 of the same bundle. This makes a same-word store-then-load or load-then-store pair within a bundle correct.

Misaligned accesses:
- A misaligned access is a half with `addr[0]`=1, or a word with `addr[1:0]`≠0.
- It never enters BUSY and no memory access is made.
- In IDLE it pulses `exN_done` and `exN_misalign`, sets `done_fN`, and stays in IDLE. Lane 1 is evaluated the next cycle.

Byte enables and store data:
- Byte: `be = 4'b0001 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
- Half: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{wdata[15:0]}}`.
- Word: `be = 4'hF`.
- Loads drive `be` by the same rules with `mem_we`=0.
- `size`=3 is treated as word.

## Timing
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` are registered.
- The request fields stay stable from the state-entry edge until the ack cycle, inclusive.
- `mem_ack` is accepted in any cycle with `mem_req`=1, including the first one.
- `mem_req` drops on the edge after ack unless the next state is BUSY1.
- With zero-wait memory:
  - a single access stalls 2 cycles (IDLE, BUSY0); `stall`=0 in cycle 3;
  - a two-access bundle stalls 3 cycles (IDLE, BUSY0, BUSY1).
- A bundle with no memory requests never stalls.
- Reset values:
  - state IDLE, `done_f*` = 0;
  - `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `mem_be` = 0;
  - `ex*_done`, `ex*_misalign` = 0; `ex*_rdata` = 0.
- Reset mid-access abandons the in-flight transaction. The memory side must tolerate `mem_req` dropping before ack.
- `mem_ack` while `mem_req`=0 is ignored.

## Structure
- Package `risc_v_32_pkg` holds:
  - the state enum `{ST_IDLE, ST_BUSY0, ST_BUSY1}`;
  - size codes `SZ_B`=0, `SZ_H`=1, `SZ_W`=2.
- Sub-module `risc_v_32_lsu_fmt` is combinational and instantiated once per lane.
  - Inputs: addr, size, wdata.
  - Outputs: be, replicated wdata, misalign.
- FSM, flags and output registers live in the top module.

## Test plan
1. **Lane 0 single sw.** `ex0_wmem`=1, addr 0x104, data 0xDEADBEEF, size 2; ack in the first BUSY cycle.
   - Expect `mem_addr`=0x104, `be`=F, `we`=1.
   - Expect `stall` high 2 cycles, then `ex0_done` pulses once.
2. **Bundle sb then lbu, same word.** Lane 0 sb 0x200+3 data 0xAB; lane 1 lbu 0x203; memory adds 2 wait cycles per access.
   - Expect lane 0 served first with `be`=1000, `wdata`=0xABABABAB.
   - Expect lane 1 read next, `ex1_rdata` = word containing 0xAB in [31:24].
   - Expect `stall` = 7 cycles.
3. **Lane-1-only lh at 0x10 (aligned) after lane 0 ALU op.**
   - Expect immediate BUSY1, `be`=0011, `ex0_done` never pulses.
4. **Misaligned lw at 0x102 on lane 0, with valid lw on lane 1.**
   - Expect `ex0_misalign` and `ex0_done` pulse with no `mem_req`.
   - Expect lane 1 served next.
5. **Reset asserted during BUSY0 wait.**
   - Next cycle: `mem_req`=0, state IDLE, `stall` reflects fresh flags.
   - A late `mem_ack` is ignored.
6. **Back-to-back bundles each with one lw, zero-wait.**
   - Expect flags cleared between bundles.
   - Expect the second access to issue 1 cycle after `stall` drops, with no lost or duplicate `done`.
